// File: rtl/bus16_arbiter_if.sv
// Requester-side bundle for bus16_arbiter: per-requester request/data in, grant and bus out.
interface bus16_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        wvalid;
  logic [N_REQ-1:0]        gnt;
  logic [IDX_W-1:0]        owner;
  logic [DATA_W-1:0]       bus_data;
  logic                    bus_valid;
  logic                    timeout;

  modport master (
    output req, wdata, wvalid,
    input  gnt, owner, bus_data, bus_valid, timeout
  );

  modport slave (
    input  req, wdata, wvalid,
    output gnt, owner, bus_data, bus_valid, timeout
  );
endinterface

// File: rtl/bus16_arbiter.sv
// Round-robin owner arbiter driving the shared 16-bit bus through a registered mux.
// Optional forced release after MAX_HOLD grant cycles: define BUS16_ARB_TIMEOUT_EN.
module bus16_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  bus16_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  bus_data_q, bus_data_d;
  logic               bus_valid_q, bus_valid_d;
  logic               timeout_q, timeout_d;
  logic [IDX_W-1:0]   sel;
  logic               found;
  logic               hold_hit;
  logic [DATA_W-1:0]  wdata_arr [N_REQ];

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % N_REQ);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      wdata_arr[i] = bus.wdata[i*DATA_W +: DATA_W];
    end
  end

  // First requester at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[wrap_idx(32'(rr_ptr_q) + k)]) begin
        found = 1'b1;
        sel   = wrap_idx(32'(rr_ptr_q) + k);
      end
    end
  end

`ifdef BUS16_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;
  assign hold_hit = bus.req[owner_q] && (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
  wire unused_max_hold = (MAX_HOLD > 1);
  assign hold_hit = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    bus_data_d  = bus_data_q;
    bus_valid_d = 1'b0;
    timeout_d   = 1'b0;
`ifdef BUS16_ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = GRANT;
          gnt_d    = N_REQ'(1) << sel;
          owner_d  = sel;
          rr_ptr_d = wrap_idx(32'(sel) + 32'd1);
`ifdef BUS16_ARB_TIMEOUT_EN
          hold_d   = '0;
`endif
        end
      end
      GRANT: begin
        bus_data_d = wdata_arr[owner_q];
        if (!bus.req[owner_q] || hold_hit) begin
          state_d   = TURN;
          gnt_d     = '0;
          timeout_d = hold_hit;
        end else begin
          bus_valid_d = bus.wvalid[owner_q];
`ifdef BUS16_ARB_TIMEOUT_EN
          hold_d      = hold_q + HOLD_W'(1);
`endif
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef BUS16_ARB_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      timeout_q   <= timeout_d;
`ifdef BUS16_ARB_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.bus_data  = bus_data_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_bus16_arbiter.sv
// Self-checking bench for bus16_arbiter: ownership model compared every cycle plus directed literals.
module tb_bus16_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MH = 16;
`ifdef BUS16_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  bus16_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  bus16_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_w(input int i, input logic [DW-1:0] v);
    bus.wdata[i*DW +: DW] = v;
  endtask

  // Ownership model: who holds the bus, how long, and the rotation pointer.
  int            m_own  = -1;
  bit            m_turn = 1'b0;
  int            m_ptr  = 0;
  int            m_last = 0;
  int            m_held = 0;
  logic [DW-1:0] m_data = '0;
  bit            m_valid = 1'b0;
  bit            m_to    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_turn = 1'b0; m_ptr = 0; m_last = 0; m_held = 0;
      m_data = '0; m_valid = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_own >= 0) begin
        m_data = bus.wdata[m_own*DW +: DW];
        if (!bus.req[m_own] || (TO_EN && m_held == MH)) begin
          m_to    = bus.req[m_own];
          m_valid = 1'b0;
          m_own   = -1;
          m_turn  = 1'b1;
        end else begin
          m_valid = bus.wvalid[m_own];
          m_held++;
        end
      end else if (m_turn) begin
        m_turn  = 1'b0;
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_own < 0 && bus.req[c]) begin
            m_own  = c;
            m_last = c;
            m_ptr  = (c + 1) % N;
            m_held = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
    check("m_gnt",       bus.gnt,       eg);
    check("m_owner",     bus.owner,     m_last);
    check("m_bus_data",  bus.bus_data,  m_data);
    check("m_bus_valid", bus.bus_valid, m_valid);
    check("m_timeout",   bus.timeout,   m_to);
  end

  int       order [5];
  int       gaps  [4];
  int       n_order, held, gap, t;
  logic [N-1:0] prev;
  logic [7:0]   pat;
  bit       to_seen;

  initial begin
    bus.req = '0; bus.wdata = '0; bus.wvalid = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("rst_gnt",       bus.gnt,       4'b0000);
    check("rst_owner",     bus.owner,     2'd0);
    check("rst_bus_data",  bus.bus_data,  16'h0000);
    check("rst_bus_valid", bus.bus_valid, 1'b0);
    check("rst_timeout",   bus.timeout,   1'b0);
    cyc(2);

    // Single requester
    set_w(2, 16'hA5A5); bus.wvalid = 4'b0100; bus.req = 4'b0100;
    cyc(1);
    check("single_gnt",   bus.gnt,       4'b0100);
    check("single_owner", bus.owner,     2'd2);
    check("single_v0",    bus.bus_valid, 1'b0);
    cyc(1);
    check("single_data",  bus.bus_data,  16'hA5A5);
    check("single_valid", bus.bus_valid, 1'b1);
    bus.req = '0;
    cyc(1);
    check("release_gnt",   bus.gnt,       4'b0000);
    check("release_valid", bus.bus_valid, 1'b0);
    cyc(1);
    check("turn_gnt",      bus.gnt,       4'b0000);
    check("turn_data",     bus.bus_data,  16'hA5A5);
    cyc(1);

    // Round-robin with all requesters active
    rst = 1'b1; cyc(1); rst = 1'b0;
    for (int i = 0; i < N; i++) set_w(i, DW'(16'h1100 * (i + 1)));
    bus.wvalid = 4'hF; bus.req = 4'hF;
    n_order = 0; held = 0; gap = 0; prev = '0;
    for (t = 0; t < 80 && n_order < 5; t++) begin
      cyc(1);
      if (bus.gnt != '0) begin
        if (prev == '0) begin
          order[n_order] = int'(bus.owner);
          if (n_order > 0) gaps[n_order-1] = gap;
          n_order++;
          held = 0;
        end
        held++;
        gap = 0;
      end else begin
        gap++;
      end
      prev = bus.gnt;
      bus.req = (held == 3 && bus.gnt != '0) ? (4'hF & ~bus.gnt) : 4'hF;
    end
    check("rr_grants_seen", n_order, 5);
    for (int k = 0; k < 5; k++) check("rr_order", order[k], k % N);
    for (int k = 0; k < 4; k++) check("rr_gap", gaps[k], 2);

    // Isolation: only owner 1's port reaches the bus
    bus.req = 4'b0010; set_w(1, 16'h1234); set_w(0, 16'hFFFF); bus.wvalid = 4'b0001;
    t = 0;
    while (bus.gnt != 4'b0010 && t < 10) begin cyc(1); t++; end
    check("iso_grant", bus.gnt, 4'b0010);
    pat = 8'b1011_0010;
    for (int j = 0; j < 8; j++) begin
      bus.wvalid = {2'b00, pat[j], 1'b1};
      cyc(1);
      check("iso_data",  bus.bus_data,  16'h1234);
      check("iso_valid", bus.bus_valid, pat[j]);
    end

    // Asynchronous reset mid-grant
    #2 rst = 1'b1;
    #1;
    check("arst_gnt",   bus.gnt,       4'b0000);
    check("arst_valid", bus.bus_valid, 1'b0);
    check("arst_data",  bus.bus_data,  16'h0000);
    check("arst_owner", bus.owner,     2'd0);
    bus.req = 4'b1000;
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    check("arst_regnt",  bus.gnt,   4'b1000);
    check("arst_reown",  bus.owner, 2'd3);
    bus.req = '0;
    cyc(3);

    // Hold-time limit
    rst = 1'b1; cyc(1); rst = 1'b0;
    bus.wvalid = 4'b0011; bus.req = 4'b0011;
    t = 0;
    while (bus.gnt != 4'b0001 && t < 5) begin cyc(1); t++; end
    check("hold_first_gnt", bus.gnt, 4'b0001);
    held = 0; to_seen = 1'b0;
    while (bus.gnt == 4'b0001 && held < 100) begin
      held++;
      if (bus.timeout) to_seen = 1'b1;
      cyc(1);
    end
`ifdef BUS16_ARB_TIMEOUT_EN
    check("hold_cycles",   held,        MH);
    check("hold_early_to", to_seen,     1'b0);
    check("to_pulse",      bus.timeout, 1'b1);
    check("to_gnt_low",    bus.gnt,     4'b0000);
    cyc(1);
    check("to_pulse_end",  bus.timeout, 1'b0);
    cyc(1);
    check("to_next_gnt",   bus.gnt,     4'b0010);
    check("to_next_owner", bus.owner,   2'd1);
`else
    check("hold_cycles",   held,        100);
    check("hold_gnt",      bus.gnt,     4'b0001);
    check("hold_no_to",    to_seen,     1'b0);
    check("hold_to_low",   bus.timeout, 1'b0);
`endif
    bus.req = '0;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
